// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and the
// bundle of stall/clear controls fed to the pipeline buffers.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WAIT  = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_stall;
    logic if_clear;
    logic idex_stall;
    logic idex_clear;
    logic exmem_stall;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t CTRL_NONE   = '0;
  localparam hazard_ctrl_t CTRL_FREEZE = '{pc_stall: 1'b1, if_stall: 1'b1, if_clear: 1'b0,
                                           idex_stall: 1'b1, idex_clear: 1'b0,
                                           exmem_stall: 1'b1};

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the stall and
// flush statistics.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc && (count_q != '1))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// whole-pipeline freeze while a multi-cycle MEM access is outstanding.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int WAIT_TIMEOUT = 1024,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              pc_stall,
  output logic              if_stall,
  output logic              if_clear,
  output logic              idex_stall,
  output logic              idex_clear,
  output logic              exmem_stall,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  localparam int WAIT_W = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(WAIT_TIMEOUT - 1);
  localparam logic [3:0]        FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  hz_state_e         state_q, state_d;
  logic [3:0]        flush_cnt_q, flush_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  hazard_ctrl_t      ctrl;
  logic              flush_evt;
  logic              load_use;
  logic              mem_block;

  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) ||
                     (id_use_rs2 && (ex_rd == id_rs2)));
  assign mem_block = mem_req && !mem_ack;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    ctrl        = CTRL_NONE;
    flush_evt   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (mem_block) begin
          ctrl       = CTRL_FREEZE;
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end else if (ex_branch_taken) begin
          // A branch wins over load-use: the dependent younger instruction is discarded.
          ctrl.if_clear   = 1'b1;
          ctrl.idex_clear = 1'b1;
          flush_evt       = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            flush_cnt_d = FLUSH_INIT;
            state_d     = ST_FLUSH;
          end
        end else if (load_use) begin
          ctrl.pc_stall   = 1'b1;
          ctrl.if_stall   = 1'b1;
          ctrl.idex_clear = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (mem_block) begin
          ctrl = CTRL_FREEZE;
        end else begin
          ctrl.if_clear = 1'b1;
          flush_cnt_d   = flush_cnt_q - 1'b1;
          if (flush_cnt_q == 4'd1) state_d = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Forced release: the last WAIT cycle lets the pipeline go.
          timeout_d = 1'b1;
          state_d   = ST_RUN;
        end else begin
          ctrl       = CTRL_FREEZE;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (ctrl.pc_stall),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (flush_evt),
    .count (flush_events)
  );

  assign pc_stall    = ctrl.pc_stall;
  assign if_stall    = ctrl.if_stall;
  assign if_clear    = ctrl.if_clear;
  assign idex_stall  = ctrl.idex_stall;
  assign idex_clear  = ctrl.idex_clear;
  assign exmem_stall = ctrl.exmem_stall;
  assign timeout_err = timeout_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller that generates the stall/clear controls consumed by the IF/ID buffer, the PC register and the ID/EX buffer.
- Detects load-use data hazards and taken branches/jumps resolved in EX.
- Freezes the whole pipeline while a multi-cycle MEM-stage access, such as a slow IO device, is outstanding.
- Keeps a small FSM for multi-cycle flush and wait, plus stall and flush statistics counters.

Parameters:
REG_AW, 5, register address width
FLUSH_CYCLES, 1, cycles of IF/ID clear per taken branch (1..15)
WAIT_TIMEOUT, 1024, max cycles in WAIT before forced release (>=2)
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock; state updates on posedge
rst  in  1  asynchronous, active-high reset
id_rs1  in  REG_AW  rs1 of instruction in ID
id_rs2  in  REG_AW  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_memread  in  1  instruction in EX is a load
ex_rd  in  REG_AW  destination of instruction in EX
ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
mem_req  in  1  MEM stage has a multi-cycle access pending
mem_ack  in  1  multi-cycle access completes this cycle
pc_stall  out  1  hold PC
if_stall  out  1  hold IF/ID buffer (its stall input)
if_clear  out  1  clear IF/ID buffer (its clear input)
idex_stall  out  1  hold ID/EX buffer
idex_clear  out  1  insert bubble into ID/EX
exmem_stall  out  1  hold EX/MEM and MEM/WB
timeout_err  out  1  sticky: a WAIT hit WAIT_TIMEOUT
stall_cycles  out  CNT_W  cycles with pc_stall=1, saturating
flush_events  out  CNT_W  accepted taken branches, saturating

Behaviour:
- Control outputs are combinational from state and inputs, so a same-cycle response is required. State and counters are registered on posedge clk.
- Reset: state=RUN, flush_cnt=0, wait_cnt=0, timeout_err=0, both stat counters 0. With inputs at 0, all control outputs are 0.
- Reset mid-FLUSH or mid-WAIT aborts immediately to RUN.
- load_use = ex_memread & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)). x0 never hazards.
- freeze means pc_stall=if_stall=idex_stall=exmem_stall=1 with all clears=0.
- State RUN, priority order:
  - mem_req & !mem_ack: freeze; wait_cnt<=0; go to WAIT.
  - mem_req & mem_ack in the same cycle: no stall from memory; evaluate the lower priorities.
  - ex_branch_taken: if_clear=1, idex_clear=1, pc not stalled (PC loads the target); flush_events++. If FLUSH_CYCLES>1, flush_cnt<=FLUSH_CYCLES-1 and go to FLUSH.
  - load_use: pc_stall=1, if_stall=1, idex_clear=1. Stay in RUN; the bubble removes the hazard on the next cycle.
  - A branch taken in the same cycle as load_use suppresses the stall, because the younger instruction is discarded.
- State FLUSH:
  - if_clear=1; flush_cnt--; return to RUN when flush_cnt reaches 1 on entry to the cycle.
  - mem_req & !mem_ack in FLUSH: freeze and hold flush_cnt; stay in FLUSH; no go to WAIT.
  - ex_branch_taken in FLUSH is ignored, since EX holds a bubble.
- State WAIT:
  - freeze while !mem_ack; wait_cnt++.
  - mem_ack: outputs all 0 this cycle; go to RUN.
  - wait_cnt==WAIT_TIMEOUT-1 without ack: timeout_err<=1, go to RUN. timeout_err clears only on rst.
- stall_cycles increments every cycle pc_stall=1 and saturates at all-ones. flush_events saturates the same way.
- if_stall and if_clear are never both 1. Verification asserts this.

Decomposition:
- Shared package holds the state enum {RUN, FLUSH, WAIT} and a hazard_ctrl_t struct bundling the six control outputs for pipeline wiring.
- One sub-module is natural: sat_counter (parameterised width, inc, clr), instantiated twice for the statistics counters.

Test Plan:
- ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> pc_stall=if_stall=idex_clear=1 that cycle only; stall_cycles=1.
- Same stimulus with ex_rd=0 -> no stall; all outputs 0.
- FLUSH_CYCLES=2, ex_branch_taken pulse -> if_clear=1 for 2 cycles, idex_clear=1 for the first only; flush_events=1.
- Branch and load_use in the same cycle -> if_clear=1, idex_clear=1, pc_stall=0.
- mem_req held, mem_ack on the 4th cycle -> freeze for 3 cycles, outputs 0 in the ack cycle; stall_cycles+=3.
- WAIT_TIMEOUT=4, mem_req with no ack -> freeze for 4 cycles, then RUN, timeout_err=1 until rst. rst asserted mid-WAIT -> RUN immediately, all outputs 0.
